// File: rtl/seg7_status_display.sv
// Four-digit multiplexed hex display of a 16-bit debug word plus I/Z/S/HALT status LEDs.
// Optional HALT blinking is compiled in when the HALT_BLINK_EN macro is defined.
module seg7_status_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        I,
  input  logic        Z,
  input  logic        S,
  input  logic        HALT,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic [3:0]  led
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TERM  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYC);

  logic [PW-1:0] psc_p0;
  logic [1:0]    idx_p0;
  logic          first_p0;
  logic [15:0]   snap_val_p0;
  logic          snap_i_p0;
  logic          snap_z_p0;
  logic          snap_s_p0;
  logic          snap_halt_p0;
  logic          tick;
  logic          frame_end;
  logic          blank_frame;
  logic [3:0]    cur_nib;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign tick      = (psc_p0 == TERM);
  assign frame_end = tick && (idx_p0 == 2'd3);
  assign cur_nib   = snap_val_p0[{idx_p0, 2'b00} +: 4];

  // Stage p0: scan timing and frame-aligned input snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_p0       <= '0;
      idx_p0       <= '0;
      first_p0     <= 1'b1;
      snap_val_p0  <= '0;
      snap_i_p0    <= 1'b0;
      snap_z_p0    <= 1'b0;
      snap_s_p0    <= 1'b0;
      snap_halt_p0 <= 1'b0;
    end else begin
      psc_p0   <= tick ? '0 : psc_p0 + 1'b1;
      first_p0 <= 1'b0;
      if (tick) idx_p0 <= idx_p0 + 2'd1;
      if (first_p0 || frame_end) begin
        snap_val_p0  <= value;
        snap_i_p0    <= I;
        snap_z_p0    <= Z;
        snap_s_p0    <= S;
        snap_halt_p0 <= HALT;
      end
    end
  end

`ifdef HALT_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FTERM = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt_p0;
  logic          phase_p0;

  // Held clear while not halted so a new halt always opens on a visible frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_p0 <= '0;
      phase_p0     <= 1'b0;
    end else if (!snap_halt_p0) begin
      frame_cnt_p0 <= '0;
      phase_p0     <= 1'b0;
    end else if (frame_end) begin
      if (frame_cnt_p0 == FTERM) begin
        frame_cnt_p0 <= '0;
        phase_p0     <= ~phase_p0;
      end else begin
        frame_cnt_p0 <= frame_cnt_p0 + 1'b1;
      end
    end
  end

  assign blank_frame = snap_halt_p0 & phase_p0;
`else
  assign blank_frame = 1'b0;
`endif

  // Stage p1: registered display drive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
      an_n  <= 4'hF;
      led   <= 4'h0;
    end else begin
      seg_n <= hex_to_seg(cur_nib);
      dp_n  <= ~((idx_p0 == 2'd3) && snap_i_p0);
      an_n  <= (blank_frame || (psc_p0 < BLANK)) ? 4'hF : ~(4'b0001 << idx_p0);
      led   <= {snap_halt_p0 & ~blank_frame, snap_i_p0, snap_s_p0, snap_z_p0};
    end
  end

endmodule
